pc_gen: RTL

//  Fetch-address generator at the head of the pipeline, driving the IF stage.

---
 rtl/pc_gen_pkg.sv | 9 +
 rtl/pc_gen_if.sv | 31 +++
 rtl/pc_gen_btb.sv | 55 +++++
 rtl/pc_gen.sv | 109 ++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-address generator.
package pc_gen_pkg;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HOLD = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the pipeline control and the PC generator.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               trap;
    logic [ADDR_W-1:0]  trap_addr;
    logic               br;
    logic [ADDR_W-1:0]  br_addr;
    logic               upd_valid;
    logic [ADDR_W-1:0]  upd_pc;
    logic [ADDR_W-1:0]  upd_target;
    logic               upd_taken;
    logic [ADDR_W-1:0]  pc_o;
    logic               pc_valid_o;
    logic               pred_taken_o;
    logic               misalign_o;

    modport master (
        output stall, trap, trap_addr, br, br_addr,
               upd_valid, upd_pc, upd_target, upd_taken,
        input  pc_o, pc_valid_o, pred_taken_o, misalign_o
    );

    modport slave (
        input  stall, trap, trap_addr, br, br_addr,
               upd_valid, upd_pc, upd_target, upd_taken,
        output pc_o, pc_valid_o, pred_taken_o, misalign_o
    );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
module pc_btb #(
    parameter int ADDR_W  = 32,
    parameter int OFS     = 2,
    parameter int ENTRIES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - OFS - IDX;

    logic [ENTRIES-1:0] vld;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             unused_lo;

    assign lk_idx    = lk_pc[OFS+IDX-1:OFS];
    assign lk_tag    = lk_pc[ADDR_W-1:OFS+IDX];
    assign up_idx    = upd_pc[OFS+IDX-1:OFS];
    assign up_tag    = upd_pc[ADDR_W-1:OFS+IDX];
    assign unused_lo = ^{lk_pc[OFS-1:0], upd_pc[OFS-1:0]};

    // Reads come straight from the registered arrays, so a same-cycle update is not visible yet.
    assign lk_hit    = vld[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_target = tgt_q[lk_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (upd_valid) begin
            if (upd_taken)
                vld[up_idx] <= 1'b1;
            else if (tag_q[up_idx] == up_tag)
                vld[up_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (upd_valid && upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_target;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator with trap/branch redirects and stall-deferred redirect.
// Optional BTB prediction is enabled with `define PC_GEN_BTB_EN.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              INST_BYTES  = 4,
    parameter int              STALL_W     = 6,
    parameter int              BTB_ENTRIES = 16
) (
    input logic   clock,
    input logic   reset,
    pc_gen_if.slave p
);
    localparam int OFS = $clog2(INST_BYTES);

    pc_state_e         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pco, pco_n;
    logic              valid, valid_n, pred, pred_n, mis, mis_n;

    logic              redirect, stalled, raw_mis, hit;
    logic [ADDR_W-1:0] raw, tgt, fa, btb_tgt, nxt;

    assign redirect = p.trap | p.br;
    assign stalled  = p.stall[0];
    assign raw      = p.trap ? p.trap_addr : p.br_addr;
    assign tgt      = raw & ~ADDR_W'(INST_BYTES - 1);
    assign raw_mis  = |raw[OFS-1:0];

    // A single BTB lookup serves both rows that advance: the redirect target or the held pc.
    assign fa  = redirect ? tgt : pc;
    assign nxt = hit ? btb_tgt : fa + ADDR_W'(INST_BYTES);

`ifdef PC_GEN_BTB_EN
    pc_btb #(
        .ADDR_W (ADDR_W),
        .OFS    (OFS),
        .ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clock     (clock),
        .reset     (reset),
        .lk_pc     (fa),
        .lk_hit    (hit),
        .lk_target (btb_tgt),
        .upd_valid (p.upd_valid),
        .upd_pc    (p.upd_pc),
        .upd_target(p.upd_target),
        .upd_taken (p.upd_taken)
    );
`else
    logic unused_upd;
    assign hit        = 1'b0;
    assign btb_tgt    = '0;
    assign unused_upd = ^{p.upd_valid, p.upd_pc, p.upd_target, p.upd_taken};
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        pco_n   = pco;
        valid_n = valid;
        pred_n  = pred;
        mis_n   = 1'b0;
        if (redirect && !stalled) begin
            pco_n   = tgt;
            pc_n    = nxt;
            valid_n = 1'b1;
            pred_n  = 1'b0;
            mis_n   = raw_mis;
            state_n = PC_RUN;
        end else if (redirect) begin
            pc_n    = tgt;
            valid_n = 1'b0;
            mis_n   = raw_mis;
            state_n = PC_HOLD;
        end else if (!stalled) begin
            // Releasing HOLD and normal RUN advance identically: the pending target already sits in pc.
            pco_n   = pc;
            pc_n    = nxt;
            valid_n = 1'b1;
            pred_n  = hit;
            state_n = PC_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PC_RUN;
            pc    <= RESET_PC;
            pco   <= '0;
            valid <= 1'b0;
            pred  <= 1'b0;
            mis   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            pco   <= pco_n;
            valid <= valid_n;
            pred  <= pred_n;
            mis   <= mis_n;
        end
    end

    assign p.pc_o         = pco;
    assign p.pc_valid_o   = valid;
    assign p.pred_taken_o = pred;
    assign p.misalign_o   = mis;
endmodule
